// File: rtl/bus_share_arbiter_if.sv
// Shared types and the grouped bus interface for bus_share_arbiter.
// The slave modport is the arbiter's view: it serves the core-side ibus/dbus
// requests and drives the downstream port. The master modport is the view of
// everything around it (core requesters plus the cache/memory side).

package bus_share_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

interface bus_share_arbiter_if;
  import bus_share_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;

  modport slave (
    input  ireq,
    input  dreq,
    input  oresp,
    output iresp,
    output dresp,
    output oreq
  );

  modport master (
    output ireq,
    output dreq,
    output oresp,
    input  iresp,
    input  dresp,
    input  oreq
  );

endinterface

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: shares one downstream data-bus port between the fetch
// requester (ibus) and the memory-stage requester (dbus). One transaction is
// outstanding at a time; the granted request is latched so the requester may
// drop valid after addr_ok. Handshake responses reach only the current owner.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's request
// ADDR  | latched request presented downstream, waiting for addr_ok
// DATA  | address accepted, waiting for data_ok

module bus_share_arbiter
  import bus_share_arbiter_pkg::*;
#(
  parameter int DBUS_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset,
  bus_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  dbus_req_t  oreq_r, oreq_d;
  dbus_req_t  oreq_c;
  ibus_resp_t iresp_c;
  dbus_resp_t dresp_c;
  logic       grant_d;
  logic       addr_ok_fwd;
  logic       data_ok_fwd;

  // dbus wins when it is the only requester or when it has priority
  assign grant_d = bus.dreq.valid && ((DBUS_FIRST != 0) || !bus.ireq.valid);

  // state, owner and latched request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      oreq_r  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      oreq_r  <= oreq_d;
    end
  end

  // next-state, grant latching and downstream request / handshake forwarding
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    oreq_d       = oreq_r;
    oreq_c       = oreq_r;
    oreq_c.valid = 1'b0;
    addr_ok_fwd  = 1'b0;
    data_ok_fwd  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // downstream responses here are stray and deliberately dropped
        if (grant_d) begin
          oreq_d       = bus.dreq;
          oreq_d.valid = 1'b0;
          owner_d      = OWN_D;
          state_d      = S_ADDR;
        end else if (bus.ireq.valid) begin
          oreq_d.valid  = 1'b0;
          oreq_d.addr   = bus.ireq.addr;
          oreq_d.size   = MSIZE4;
          oreq_d.strobe = '0;
          oreq_d.data   = '0;
          owner_d       = OWN_I;
          state_d       = S_ADDR;
        end
      end

      S_ADDR: begin
        oreq_c.valid = 1'b1;
        // data_ok without addr_ok is ignored; stay in ADDR
        if (bus.oresp.addr_ok) begin
          addr_ok_fwd = 1'b1;
          if (bus.oresp.data_ok) begin
            data_ok_fwd = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // address fields stay on oreq for debug visibility with valid low
        if (bus.oresp.data_ok) begin
          data_ok_fwd = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // route handshakes to the owner only; data mirrors downstream at all times
  always_comb begin
    iresp_c         = '0;
    dresp_c         = '0;
    iresp_c.data    = bus.oresp.data;
    dresp_c.data    = bus.oresp.data;
    iresp_c.addr_ok = addr_ok_fwd && (owner_q == OWN_I);
    iresp_c.data_ok = data_ok_fwd && (owner_q == OWN_I);
    dresp_c.addr_ok = addr_ok_fwd && (owner_q == OWN_D);
    dresp_c.data_ok = data_ok_fwd && (owner_q == OWN_D);
  end

  assign bus.oreq  = oreq_c;
  assign bus.iresp = iresp_c;
  assign bus.dresp = dresp_c;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed bench for bus_share_arbiter. Two instances share the downstream
// response stimulus: u_dut0 with dbus priority, u_dut1 with ibus priority.
// u_dut1 has its own requesters and stays idle except in the arbitration test.

module tb_bus_share_arbiter;
  import bus_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  bus_share_arbiter_if bif0 ();
  bus_share_arbiter_if bif1 ();

  assign bif1.oresp = bif0.oresp;

  bus_share_arbiter #(.DBUS_FIRST(1)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif0.slave)
  );

  bus_share_arbiter #(.DBUS_FIRST(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bif0.ireq  = '0;
    bif0.dreq  = '0;
    bif0.oresp = '0;
    bif1.ireq  = '0;
    bif1.dreq  = '0;

    // reset state
    #2;
    chk("rst_oreq_valid", bif0.oreq.valid, 0);
    chk("rst_oreq_addr", bif0.oreq.addr, 0);
    chk("rst_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    chk("rst_dresp_hs", {bif0.dresp.addr_ok, bif0.dresp.data_ok}, 0);
    step();
    reset = 1'b0;

    // lone ibus request
    bif0.ireq.valid = 1'b1;
    bif0.ireq.addr  = 32'hBFC0_0000;
    #1;
    chk("i_c0_oreq_valid", bif0.oreq.valid, 0);
    step();
    #1;
    chk("i_c1_oreq_valid", bif0.oreq.valid, 1);
    chk("i_c1_oreq_addr", bif0.oreq.addr, 32'hBFC0_0000);
    chk("i_c1_oreq_size", bif0.oreq.size, MSIZE4);
    chk("i_c1_oreq_strobe", bif0.oreq.strobe, 0);
    chk("i_c1_oreq_data", bif0.oreq.data, 0);
    chk("i_c1_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    step();
    bif0.oresp.addr_ok = 1'b1;
    #1;
    chk("i_c2_oreq_valid", bif0.oreq.valid, 1);
    chk("i_c2_iresp_addr_ok", bif0.iresp.addr_ok, 1);
    chk("i_c2_iresp_data_ok", bif0.iresp.data_ok, 0);
    chk("i_c2_dresp_hs", {bif0.dresp.addr_ok, bif0.dresp.data_ok}, 0);
    step();
    bif0.oresp.addr_ok = 1'b0;
    bif0.ireq.valid    = 1'b0;
    #1;
    chk("i_c3_oreq_valid", bif0.oreq.valid, 0);
    chk("i_c3_oreq_addr", bif0.oreq.addr, 32'hBFC0_0000);
    chk("i_c3_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    step();
    bif0.oresp.data_ok = 1'b1;
    bif0.oresp.data    = 32'h2408_0001;
    #1;
    chk("i_c4_iresp_data_ok", bif0.iresp.data_ok, 1);
    chk("i_c4_iresp_data", bif0.iresp.data, 32'h2408_0001);
    chk("i_c4_dresp_hs", {bif0.dresp.addr_ok, bif0.dresp.data_ok}, 0);
    chk("i_c4_dresp_data", bif0.dresp.data, 32'h2408_0001);
    chk("d1_idle_stray_hs", {bif1.iresp.addr_ok, bif1.iresp.data_ok,
                             bif1.dresp.addr_ok, bif1.dresp.data_ok}, 0);
    step();
    bif0.oresp.data_ok = 1'b0;
    #1;
    chk("i_c5_oreq_valid", bif0.oreq.valid, 0);
    chk("i_c5_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);

    // simultaneous requests on both priority settings
    bif0.ireq.valid  = 1'b1;
    bif0.ireq.addr   = 32'h0000_0100;
    bif0.dreq.valid  = 1'b1;
    bif0.dreq.addr   = 32'h0000_0200;
    bif0.dreq.size   = MSIZE4;
    bif0.dreq.strobe = 4'hF;
    bif0.dreq.data   = 32'hDEAD_BEEF;
    bif1.ireq        = bif0.ireq;
    bif1.dreq        = bif0.dreq;
    #1;
    step();
    bif0.oresp.addr_ok = 1'b1;
    bif0.oresp.data_ok = 1'b1;
    bif0.oresp.data    = 32'h1111_2222;
    #1;
    chk("s1_d0_oreq_addr", bif0.oreq.addr, 32'h200);
    chk("s1_d0_oreq_strobe", bif0.oreq.strobe, 4'hF);
    chk("s1_d0_oreq_data", bif0.oreq.data, 32'hDEAD_BEEF);
    chk("s1_d0_dresp_hs", {bif0.dresp.addr_ok, bif0.dresp.data_ok}, 2'b11);
    chk("s1_d0_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    chk("s1_d1_oreq_addr", bif1.oreq.addr, 32'h100);
    chk("s1_d1_oreq_strobe", bif1.oreq.strobe, 0);
    chk("s1_d1_iresp_hs", {bif1.iresp.addr_ok, bif1.iresp.data_ok}, 2'b11);
    chk("s1_d1_dresp_hs", {bif1.dresp.addr_ok, bif1.dresp.data_ok}, 0);
    step();
    bif0.oresp.addr_ok = 1'b0;
    bif0.oresp.data_ok = 1'b0;
    bif0.dreq.valid    = 1'b0;
    bif1.ireq.valid    = 1'b0;
    #1;
    chk("s2_d0_idle_valid", bif0.oreq.valid, 0);
    chk("s2_d1_idle_valid", bif1.oreq.valid, 0);
    step();
    bif0.oresp.addr_ok = 1'b1;
    bif0.oresp.data_ok = 1'b1;
    #1;
    chk("s3_d0_oreq_valid", bif0.oreq.valid, 1);
    chk("s3_d0_oreq_addr", bif0.oreq.addr, 32'h100);
    chk("s3_d0_oreq_strobe", bif0.oreq.strobe, 0);
    chk("s3_d0_iresp_data_ok", bif0.iresp.data_ok, 1);
    chk("s3_d1_oreq_addr", bif1.oreq.addr, 32'h200);
    chk("s3_d1_oreq_strobe", bif1.oreq.strobe, 4'hF);
    chk("s3_d1_dresp_data_ok", bif1.dresp.data_ok, 1);
    bif0.ireq = '0;
    bif0.dreq = '0;
    bif1.ireq = '0;
    bif1.dreq = '0;
    step();
    bif0.oresp.addr_ok = 1'b0;
    bif0.oresp.data_ok = 1'b0;
    #1;
    chk("s4_d0_idle_valid", bif0.oreq.valid, 0);
    chk("s4_d1_idle_valid", bif1.oreq.valid, 0);

    // spurious data_ok in ADDR, then requester changes fields during DATA
    bif0.dreq.valid  = 1'b1;
    bif0.dreq.addr   = 32'h0000_0400;
    bif0.dreq.size   = MSIZE1;
    bif0.dreq.strobe = 4'h3;
    bif0.dreq.data   = 32'h55AA_55AA;
    #1;
    step();
    bif0.oresp.data_ok = 1'b1;
    bif0.oresp.data    = 32'hCAFE_0000;
    #1;
    chk("c1_spur_dresp_data_ok", bif0.dresp.data_ok, 0);
    chk("c1_oreq_size", bif0.oreq.size, MSIZE1);
    step();
    bif0.oresp.data_ok = 1'b0;
    bif0.oresp.addr_ok = 1'b1;
    #1;
    chk("c2_still_addr_valid", bif0.oreq.valid, 1);
    chk("c2_dresp_addr_ok", bif0.dresp.addr_ok, 1);
    step();
    bif0.oresp.addr_ok = 1'b0;
    bif0.dreq.valid    = 1'b0;
    bif0.dreq.addr     = 32'h0000_0300;
    #1;
    chk("c3_oreq_valid", bif0.oreq.valid, 0);
    chk("c3_oreq_addr_latched", bif0.oreq.addr, 32'h400);
    step();
    bif0.oresp.data_ok = 1'b1;
    bif0.oresp.data    = 32'h8765_4321;
    #1;
    chk("c4_dresp_data_ok", bif0.dresp.data_ok, 1);
    chk("c4_dresp_data", bif0.dresp.data, 32'h8765_4321);
    chk("c4_iresp_data_ok", bif0.iresp.data_ok, 0);
    chk("c4_oreq_addr_latched", bif0.oreq.addr, 32'h400);
    step();
    bif0.oresp.data_ok = 1'b0;
    bif0.dreq          = '0;

    // async reset while in DATA
    bif0.ireq.valid = 1'b1;
    bif0.ireq.addr  = 32'h0000_1000;
    #1;
    step();
    bif0.oresp.addr_ok = 1'b1;
    #1;
    step();
    bif0.oresp.addr_ok = 1'b0;
    bif0.ireq.valid    = 1'b0;
    #1;
    chk("r_data_oreq_addr", bif0.oreq.addr, 32'h1000);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async_oreq_valid", bif0.oreq.valid, 0);
    chk("r_async_oreq_addr", bif0.oreq.addr, 0);
    bif0.oresp.data_ok = 1'b1;
    #1;
    chk("r_in_rst_iresp_data_ok", bif0.iresp.data_ok, 0);
    step();
    reset = 1'b0;
    #1;
    chk("r_after_iresp_data_ok", bif0.iresp.data_ok, 0);
    chk("r_after_dresp_data_ok", bif0.dresp.data_ok, 0);
    step();
    bif0.oresp.data_ok = 1'b0;
    #1;
    chk("r_after_oreq_valid", bif0.oreq.valid, 0);

    // stray downstream responses with nothing pending
    bif0.oresp.addr_ok = 1'b1;
    bif0.oresp.data_ok = 1'b1;
    #1;
    chk("st_iresp_hs", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    chk("st_dresp_hs", {bif0.dresp.addr_ok, bif0.dresp.data_ok}, 0);
    step();
    #1;
    chk("st_oreq_valid", bif0.oreq.valid, 0);
    chk("st_iresp_hs2", {bif0.iresp.addr_ok, bif0.iresp.data_ok}, 0);
    bif0.oresp = '0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
